// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. Drives the write
//   enables and flushes of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB
//   registers. It reacts to load-use hazards, taken branches, multi-cycle
//   divides, I/D memory busy and exceptions in MEM. The only state is the
//   divide-occupancy FSM and its down-counter. All pipeline controls are
//   decoded combinationally from that state and the current inputs, so they
//   take effect in the same cycle.
//
// Parameters
//   DIV_CYCLES     cycles a divide occupies EX (must be >= 2)
//
// Ports
//   clk, rst       pipeline clock; asynchronous active-high reset
//   ID_rs, ID_rt   source registers of the instruction in ID
//   EX_MemRead     instruction in EX is a load
//   EX_rt          destination register of that load
//   EX_BranchTaken branch/jump in EX resolved taken
//   EX_DivStart    divide instruction valid in EX (level)
//   I_Busy         fetch not ready this cycle
//   D_Busy         data memory access in MEM not ready this cycle
//   MEM_Exception  instruction in MEM raises an exception
//   PC_Wr .. MEMWB_Flush  pipeline register enables and clears
//   Div_Busy       divider FSM is in S_DIV
//   Div_Done       divide result valid this cycle
//   Div_Cancel     abort the divider this cycle
//
// State  | meaning
// S_RUN  | no divide in flight; cnt is 0
// S_DIV  | divide occupying EX; cnt counts down the cycles left, 1 = done
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int DIV_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_rt,
    input  logic       EX_BranchTaken,
    input  logic       EX_DivStart,
    input  logic       I_Busy,
    input  logic       D_Busy,
    input  logic       MEM_Exception,
    output logic       PC_Wr,
    output logic       IF_IDWr,
    output logic       IFID_Flush,
    output logic       ID_EXWr,
    output logic       IDEX_Flush,
    output logic       EX_MEMWr,
    output logic       EXMEM_Flush,
    output logic       MEMWB_Flush,
    output logic       Div_Busy,
    output logic       Div_Done,
    output logic       Div_Cancel
);

    localparam int               CNT_W    = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        S_RUN = 1'b0,
        S_DIV = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic load_use;
    logic div_stall;
    logic cnt_is_one;

    assign cnt_is_one = (cnt_q == CNT_ONE);
    assign load_use   = EX_MemRead && (EX_rt != 5'd0) &&
                        ((EX_rt == ID_rs) || (EX_rt == ID_rt));
    assign div_stall  = ((state_q == S_RUN) && EX_DivStart) ||
                        ((state_q == S_DIV) && !cnt_is_one);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                if (EX_DivStart && !MEM_Exception) begin
                    state_d = S_DIV;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_DIV: begin
                if (MEM_Exception) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else if (cnt_q > CNT_ONE) begin
                    // The divider runs on its own, so it keeps counting even while MEM is busy.
                    cnt_d = cnt_q - CNT_ONE;
                end else if (!D_Busy) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end
                // When cnt is 1 and D_Busy is set, hold the state so the finished result stays presented.
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        PC_Wr       = 1'b1;
        IF_IDWr     = 1'b1;
        IFID_Flush  = 1'b0;
        ID_EXWr     = 1'b1;
        IDEX_Flush  = 1'b0;
        EX_MEMWr    = 1'b1;
        EXMEM_Flush = 1'b0;
        MEMWB_Flush = 1'b0;
        Div_Busy    = (state_q == S_DIV);
        Div_Done    = (state_q == S_DIV) && cnt_is_one && !MEM_Exception;
        Div_Cancel  = MEM_Exception && ((state_q == S_DIV) || EX_DivStart);

        if (MEM_Exception) begin
            PC_Wr       = 1'b1;
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
            MEMWB_Flush = 1'b1;
        end else if (D_Busy) begin
            PC_Wr       = 1'b0;
            IF_IDWr     = 1'b0;
            ID_EXWr     = 1'b0;
            EX_MEMWr    = 1'b0;
            MEMWB_Flush = 1'b1;
        end else if (div_stall) begin
            PC_Wr       = 1'b0;
            IF_IDWr     = 1'b0;
            ID_EXWr     = 1'b0;
            EXMEM_Flush = 1'b1;
        end else if (load_use) begin
            PC_Wr      = 1'b0;
            IF_IDWr    = 1'b0;
            IDEX_Flush = 1'b1;
        end else if (EX_BranchTaken) begin
            PC_Wr      = 1'b1;
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else if (I_Busy) begin
            PC_Wr      = 1'b0;
            IFID_Flush = 1'b1;
        end

        // Reset freezes and clears the whole pipeline in the same cycle it is asserted.
        if (rst) begin
            PC_Wr       = 1'b0;
            IF_IDWr     = 1'b0;
            IFID_Flush  = 1'b1;
            ID_EXWr     = 1'b0;
            IDEX_Flush  = 1'b1;
            EX_MEMWr    = 1'b0;
            EXMEM_Flush = 1'b1;
            MEMWB_Flush = 1'b1;
            Div_Busy    = 1'b0;
            Div_Done    = 1'b0;
            Div_Cancel  = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//   Directed bench for pipeline_hazard_ctrl with DIV_CYCLES = 4. Outputs are
//   packed into one 11-bit word so that each check compares the full control
//   state. The bit order, from MSB to LSB, is:
//   PC_Wr IF_IDWr IFID_Flush ID_EXWr IDEX_Flush EX_MEMWr EXMEM_Flush
//   MEMWB_Flush Div_Busy Div_Done Div_Cancel
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_rs, ID_rt, EX_rt;
    logic       EX_MemRead, EX_BranchTaken, EX_DivStart;
    logic       I_Busy, D_Busy, MEM_Exception;
    logic       PC_Wr, IF_IDWr, IFID_Flush, ID_EXWr, IDEX_Flush;
    logic       EX_MEMWr, EXMEM_Flush, MEMWB_Flush;
    logic       Div_Busy, Div_Done, Div_Cancel;

    int tests_run = 0;
    int tests_failed = 0;

    // Expected words are hand-computed from the hazard priority table.
    localparam logic [10:0] V_DEFAULT  = 11'b1_1_0_1_0_1_0_0_000;
    localparam logic [10:0] V_RESET    = 11'b0_0_1_0_1_0_1_1_000;
    localparam logic [10:0] V_LOADUSE  = 11'b0_0_0_1_1_1_0_0_000;
    localparam logic [10:0] V_DIV_ST0  = 11'b0_0_0_0_0_1_1_0_000;
    localparam logic [10:0] V_DIV_STB  = 11'b0_0_0_0_0_1_1_0_100;
    localparam logic [10:0] V_DIV_DONE = 11'b1_1_0_1_0_1_0_0_110;
    localparam logic [10:0] V_DONE_DB  = 11'b0_0_0_0_0_0_0_1_110;
    localparam logic [10:0] V_DBUSY    = 11'b0_0_0_0_0_0_0_1_000;
    localparam logic [10:0] V_EXC_DIV  = 11'b1_1_1_1_1_1_1_1_101;
    localparam logic [10:0] V_EXC_RUNC = 11'b1_1_1_1_1_1_1_1_001;
    localparam logic [10:0] V_BR       = 11'b1_1_1_1_1_1_0_0_000;
    localparam logic [10:0] V_IBUSY    = 11'b0_1_1_1_0_1_0_0_000;

    logic [10:0] obs;
    assign obs = {PC_Wr, IF_IDWr, IFID_Flush, ID_EXWr, IDEX_Flush, EX_MEMWr,
                  EXMEM_Flush, MEMWB_Flush, Div_Busy, Div_Done, Div_Cancel};

    pipeline_hazard_ctrl #(.DIV_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .ID_rs          (ID_rs),
        .ID_rt          (ID_rt),
        .EX_MemRead     (EX_MemRead),
        .EX_rt          (EX_rt),
        .EX_BranchTaken (EX_BranchTaken),
        .EX_DivStart    (EX_DivStart),
        .I_Busy         (I_Busy),
        .D_Busy         (D_Busy),
        .MEM_Exception  (MEM_Exception),
        .PC_Wr          (PC_Wr),
        .IF_IDWr        (IF_IDWr),
        .IFID_Flush     (IFID_Flush),
        .ID_EXWr        (ID_EXWr),
        .IDEX_Flush     (IDEX_Flush),
        .EX_MEMWr       (EX_MEMWr),
        .EXMEM_Flush    (EXMEM_Flush),
        .MEMWB_Flush    (MEMWB_Flush),
        .Div_Busy       (Div_Busy),
        .Div_Done       (Div_Done),
        .Div_Cancel     (Div_Cancel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [10:0] got, input logic [10:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic idle();
        ID_rs = 5'd1; ID_rt = 5'd2; EX_rt = 5'd3;
        EX_MemRead = 1'b0; EX_BranchTaken = 1'b0; EX_DivStart = 1'b0;
        I_Busy = 1'b0; D_Busy = 1'b0; MEM_Exception = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge. Checks happen 1 time unit after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #2;
        chk("reset_hold", obs, V_RESET);
        tick();
        rst = 1'b0;
        #1 chk("reset_release", obs, V_DEFAULT);

        // load-use on rs, on rt, then with x0 as the destination
        tick();
        EX_MemRead = 1'b1; EX_rt = 5'd5; ID_rs = 5'd5;
        #1 chk("load_use_rs", obs, V_LOADUSE);
        tick();
        EX_MemRead = 1'b0;
        #1 chk("load_use_clears", obs, V_DEFAULT);
        tick();
        EX_MemRead = 1'b1; EX_rt = 5'd7; ID_rs = 5'd1; ID_rt = 5'd7;
        #1 chk("load_use_rt", obs, V_LOADUSE);
        tick();
        EX_rt = 5'd0; ID_rs = 5'd0; ID_rt = 5'd0;
        #1 chk("load_use_x0", obs, V_DEFAULT);
        tick();
        idle();

        // plain divide, EX_DivStart held for 4 cycles
        EX_DivStart = 1'b1;
        #1 chk("div_c0", obs, V_DIV_ST0);
        tick(); #1 chk("div_c1", obs, V_DIV_STB);
        tick(); #1 chk("div_c2", obs, V_DIV_STB);
        tick(); #1 chk("div_c3_done", obs, V_DIV_DONE);
        tick();
        EX_DivStart = 1'b0;
        #1 chk("div_c4", obs, V_DEFAULT);

        // divide with D_Busy during the done cycle
        tick();
        EX_DivStart = 1'b1;
        #1 chk("divdb_c0", obs, V_DIV_ST0);
        tick(); #1 chk("divdb_c1", obs, V_DIV_STB);
        tick(); #1 chk("divdb_c2", obs, V_DIV_STB);
        tick();
        D_Busy = 1'b1;
        #1 chk("divdb_c3", obs, V_DONE_DB);
        tick();
        D_Busy = 1'b0;
        #1 chk("divdb_c4_held", obs, V_DIV_DONE);
        tick();
        EX_DivStart = 1'b0;
        #1 chk("divdb_c5_run", obs, V_DEFAULT);

        // exception while in S_DIV with cnt = 2
        tick();
        EX_DivStart = 1'b1;
        tick();
        tick();
        EX_DivStart = 1'b0; MEM_Exception = 1'b1;
        #1 chk("exc_in_div", obs, V_EXC_DIV);
        tick();
        MEM_Exception = 1'b0;
        #1 chk("exc_after", obs, V_DEFAULT);

        // exception arriving together with a divide start cancels the start
        tick();
        EX_DivStart = 1'b1; MEM_Exception = 1'b1;
        #1 chk("exc_div_start", obs, V_EXC_RUNC);
        tick();
        EX_DivStart = 1'b0; MEM_Exception = 1'b0;
        #1 chk("exc_div_start_after", obs, V_DEFAULT);

        // D_Busy alone; taken branch overrides I_Busy; I_Busy alone
        tick();
        D_Busy = 1'b1;
        #1 chk("d_busy", obs, V_DBUSY);
        tick();
        D_Busy = 1'b0; EX_BranchTaken = 1'b1; I_Busy = 1'b1;
        #1 chk("branch_ibusy", obs, V_BR);
        tick();
        EX_BranchTaken = 1'b0;
        #1 chk("i_busy", obs, V_IBUSY);
        tick();
        idle();

        // asynchronous reset applied mid-divide, when S_DIV has cnt = 2
        EX_DivStart = 1'b1;
        tick();
        tick();
        #1 chk("pre_rst_div", obs, V_DIV_STB);
        rst = 1'b1;
        #1 chk("rst_in_div", obs, V_RESET);
        tick();
        rst = 1'b0; EX_DivStart = 1'b0;
        #1 chk("rst_release_div", obs, V_DEFAULT);
        tick();
        #1 chk("rst_state_run", obs, V_DEFAULT);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
